// File: rtl/signal_cfg_pkg.sv
// Shared constants, state encoding and field word map for the signal config slice.
package signal_cfg_pkg;

    localparam int CFG_WORDS = 26;
    localparam int CFG_WIDTH = 32 * CFG_WORDS;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } cfg_state_t;

    // Field groups: ramp occupies words 0..1, then four 6-word compensation blocks.
    localparam int RAMP_WORD_LO    = 0;
    localparam int RAMP_WORD_HI    = 1;
    localparam int COMP_BASE_WORD  = 2;
    localparam int COMP_BLOCK_SIZE = 6;

    function automatic int comp_word(input int n, input int offset);
        return COMP_BASE_WORD + COMP_BLOCK_SIZE * n + offset;
    endfunction

endpackage

// File: rtl/signal_cfg_word_reg.sv
// One 32-bit shadow word with per-byte write enables.
module signal_cfg_word_reg (
    input  logic        aclk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [3:0]  wr_strb,
    input  logic [31:0] wr_data,
    output logic [31:0] q
);

    always_ff @(posedge aclk) begin
        if (reset) begin
            q <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) begin
                    q[8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/signal_cfg_shadow_bank.sv
// Shadow register bank that assembles config words and commits them atomically
// to the active vector on a period boundary or a forced commit.
module signal_cfg_shadow_bank
    import signal_cfg_pkg::*;
#(
    parameter int WORDS      = 26,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [31:0]           wr_data,
    input  logic [3:0]            wr_strb,
    input  logic                  commit_req,
    input  logic                  update_tick,
    input  logic                  force_commit,
    output logic [32*WORDS-1:0]   cfg_data,
    output logic                  pending,
    output logic                  commit_done,
    output logic                  wr_err,
    output logic [CNT_WIDTH-1:0]  commit_count
);

    localparam logic [ADDR_WIDTH:0] WORDS_LIMIT = (ADDR_WIDTH + 1)'(WORDS);

    logic [32*WORDS-1:0] shadow;
    logic                addr_valid;
    logic                do_commit;
    cfg_state_t          state;
    cfg_state_t          state_next;

    assign addr_valid = ({1'b0, wr_addr} < WORDS_LIMIT);

    for (genvar k = 0; k < WORDS; k++) begin : g_word
        signal_cfg_word_reg u_word (
            .aclk    (aclk),
            .reset   (reset),
            .wr_en   (wr_en && (wr_addr == ADDR_WIDTH'(k))),
            .wr_strb (wr_strb),
            .wr_data (wr_data),
            .q       (shadow[32*k +: 32])
        );
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (force_commit) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (commit_req && !update_tick) state_next = ARMED;
                ARMED:   if (update_tick) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // A tick in IDLE commits only when it coincides with a fresh request.
    always_comb begin
        pending   = (state == ARMED);
        do_commit = force_commit
                  || ((state == IDLE) && commit_req && update_tick)
                  || ((state == ARMED) && update_tick);
    end

    // The active copy samples shadow before any same-edge write lands in it.
    always_ff @(posedge aclk) begin
        if (reset) begin
            cfg_data     <= '0;
            commit_done  <= 1'b0;
            wr_err       <= 1'b0;
            commit_count <= '0;
        end else begin
            commit_done <= do_commit;
            wr_err      <= wr_en && !addr_valid;
            if (do_commit) begin
                cfg_data     <= shadow;
                commit_count <= commit_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_signal_cfg_shadow_bank.sv
// Directed self-checking bench for signal_cfg_shadow_bank.
module tb_signal_cfg_shadow_bank;

    logic         aclk = 1'b0;
    logic         reset;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [31:0]  wr_data;
    logic [3:0]   wr_strb;
    logic         commit_req;
    logic         update_tick;
    logic         force_commit;
    logic [831:0] cfg_data;
    logic         pending;
    logic         commit_done;
    logic         wr_err;
    logic [15:0]  commit_count;

    int passed = 0;
    int total  = 0;

    signal_cfg_shadow_bank #(
        .WORDS      (26),
        .ADDR_WIDTH (5),
        .CNT_WIDTH  (16)
    ) dut (
        .aclk         (aclk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_strb      (wr_strb),
        .commit_req   (commit_req),
        .update_tick  (update_tick),
        .force_commit (force_commit),
        .cfg_data     (cfg_data),
        .pending      (pending),
        .commit_done  (commit_done),
        .wr_err       (wr_err),
        .commit_count (commit_count)
    );

    always #5 aclk = ~aclk;

    function automatic logic [31:0] active_word(input int k);
        return cfg_data[32*k +: 32];
    endfunction

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic write_word(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        wr_strb = strb;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_force();
        force_commit = 1'b1;
        step();
        force_commit = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
        commit_req = 1'b0; update_tick = 1'b0; force_commit = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("reset_cfg", cfg_data[63:0], 64'h0);
        check("reset_count", commit_count, 16'd0);
        check("reset_pending", pending, 1'b0);
        check("reset_done", commit_done, 1'b0);
        check("reset_wr_err", wr_err, 1'b0);

        // Two-word write then forced commit
        write_word(5'd0, 32'h12345678, 4'hF);
        write_word(5'd1, 32'h0000ABCD, 4'hF);
        check("shadow_hidden", cfg_data[63:0], 64'h0);
        pulse_force();
        check("force_cfg", cfg_data[63:0], 64'h0000ABCD_12345678);
        check("force_done", commit_done, 1'b1);
        check("force_count", commit_count, 16'd1);
        step();
        check("force_done_clear", commit_done, 1'b0);

        // Armed commit waits ten cycles for the tick
        write_word(5'd0, 32'h11111111, 4'hF);
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        check("armed_pending_0", pending, 1'b1);
        for (int i = 1; i < 10; i++) begin
            step();
            check("armed_pending", pending, 1'b1);
            check("armed_cfg_hold", active_word(0), 32'h12345678);
            check("armed_no_done", commit_done, 1'b0);
        end
        update_tick = 1'b1;
        step();
        update_tick = 1'b0;
        check("tick_cfg", active_word(0), 32'h11111111);
        check("tick_done", commit_done, 1'b1);
        check("tick_pending", pending, 1'b0);
        check("tick_count", commit_count, 16'd2);
        step();
        check("tick_done_once", commit_done, 1'b0);

        // Byte strobes
        write_word(5'd2, 32'hFFFFFFFF, 4'hF);
        pulse_force();
        check("strb_pre", active_word(2), 32'hFFFFFFFF);
        write_word(5'd2, 32'h00000000, 4'b0101);
        pulse_force();
        check("strb_cfg", active_word(2), 32'hFF00FF00);
        check("strb_count", commit_count, 16'd4);

        // Out-of-range write
        write_word(5'd26, 32'hDEADBEEF, 4'hF);
        check("oor_err", wr_err, 1'b1);
        step();
        check("oor_err_clear", wr_err, 1'b0);
        pulse_force();
        check("oor_w0", active_word(0), 32'h11111111);
        check("oor_w1", active_word(1), 32'h0000ABCD);
        check("oor_w2", active_word(2), 32'hFF00FF00);
        check("oor_w25", active_word(25), 32'h0);
        check("oor_count", commit_count, 16'd5);

        // Write coinciding with the committing tick lands in shadow only
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        check("coll_pending", pending, 1'b1);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hA5A5A5A5; wr_strb = 4'hF;
        update_tick = 1'b1;
        step();
        wr_en = 1'b0; update_tick = 1'b0;
        check("coll_old", active_word(5), 32'h0);
        check("coll_done", commit_done, 1'b1);
        check("coll_count", commit_count, 16'd6);
        pulse_force();
        check("coll_new", active_word(5), 32'hA5A5A5A5);
        check("coll_count2", commit_count, 16'd7);

        // Force while armed drops the armed commit
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        check("farm_pending", pending, 1'b1);
        pulse_force();
        check("farm_pending_clr", pending, 1'b0);
        check("farm_count", commit_count, 16'd8);
        update_tick = 1'b1;
        step();
        update_tick = 1'b0;
        check("farm_tick_done", commit_done, 1'b0);
        check("farm_tick_count", commit_count, 16'd8);

        // Request and tick together in IDLE commit at once
        write_word(5'd3, 32'hCAFEF00D, 4'hF);
        commit_req = 1'b1; update_tick = 1'b1;
        step();
        commit_req = 1'b0; update_tick = 1'b0;
        check("same_cfg", active_word(3), 32'hCAFEF00D);
        check("same_pending", pending, 1'b0);
        check("same_count", commit_count, 16'd9);
        update_tick = 1'b1;
        step();
        update_tick = 1'b0;
        check("idle_tick_done", commit_done, 1'b0);
        check("idle_tick_count", commit_count, 16'd9);

        // Reset while armed
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        check("rst_armed", pending, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_pending", pending, 1'b0);
        update_tick = 1'b1;
        step();
        update_tick = 1'b0;
        check("rst_tick_done", commit_done, 1'b0);
        check("rst_cfg_w0", active_word(0), 32'h0);
        check("rst_cfg_w5", active_word(5), 32'h0);
        check("rst_count", commit_count, 16'd0);
        check("rst_pending2", pending, 1'b0);

        // Counter wrap
        force_commit = 1'b1;
        for (int i = 0; i < 65535; i++) step();
        check("wrap_max", commit_count, 16'hFFFF);
        step();
        force_commit = 1'b0;
        check("wrap_zero", commit_count, 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
